id_ex_stage: RTL and testbench

ID/EX pipeline register for the MIPS pipeline, with integrated load-use hazard detection. Each cycle it captures the decoded instruction from ID: register addresses, control bits and operand data. It presents them to EX and to the forwarding unit, which consumes `ex_rs`, `ex_rt`, `ex_rd` and `ex_regwrite`. It also stalls PC and IF/ID for one cycle on a load-use dependency and inserts a bubble. A branch flush and a saturating stall counter are included.

---
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating count of load-use stalls.
module id_ex_stage #(
   parameter int unsigned REG_ADDR_W = 2,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  id_memwrite,
   input  logic                  id_memtoreg,
   input  logic                  id_alusrc,
   input  logic                  id_regdst,
   input  logic [1:0]            id_aluop,
   input  logic [DATA_W-1:0]     id_rdata1,
   input  logic [DATA_W-1:0]     id_rdata2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic                  flush,
   input  logic                  cnt_clr,
   output logic                  ex_valid,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_regwrite,
   output logic                  ex_memread,
   output logic                  ex_memwrite,
   output logic                  ex_memtoreg,
   output logic                  ex_alusrc,
   output logic                  ex_regdst,
   output logic [1:0]            ex_aluop,
   output logic [DATA_W-1:0]     ex_rdata1,
   output logic [DATA_W-1:0]     ex_rdata2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic hazard;
   logic bubble;
   logic cnt_sat;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   always_comb begin
      hazard = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
               ((id_rs_used & (id_rs == ex_rt)) | (id_rt_used & (id_rt == ex_rt)));
      stall  = hazard & ~flush;
      bubble = flush | stall;
      cnt_sat = &stall_cnt;
   end

   // Addresses and data are captured even on a bubble; only valid and control bits are
   // squashed, which also guarantees a stall never repeats on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_regdst   <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_rdata1   <= '0;
         ex_rdata2   <= '0;
         ex_imm      <= '0;
      end else begin
         ex_rs     <= id_rs;
         ex_rt     <= id_rt;
         ex_rd     <= id_rd;
         ex_rdata1 <= id_rdata1;
         ex_rdata2 <= id_rdata2;
         ex_imm    <= id_imm;
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_aluop    <= 2'b00;
         end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_memtoreg <= id_memtoreg;
            ex_alusrc   <= id_alusrc;
            ex_regdst   <= id_regdst;
            ex_aluop    <= id_aluop;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stall && !cnt_sat) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/counter cases plus
// randomized traffic scored against a small behavioural model.
module tb_id_ex_stage;

   localparam int unsigned CNT_MAX = 3;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [1:0] id_rs, id_rt, id_rd;
   logic       id_rs_used, id_rt_used;
   logic [5:0] id_ctl;  // {regwrite, memread, memwrite, memtoreg, alusrc, regdst}
   logic [1:0] id_aluop;
   logic [7:0] id_rdata1, id_rdata2, id_imm;
   logic       flush, cnt_clr;

   logic       ex_valid;
   logic [1:0] ex_rs, ex_rt, ex_rd;
   logic       ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst;
   logic [1:0] ex_aluop;
   logic [7:0] ex_rdata1, ex_rdata2, ex_imm;
   logic       stall;
   logic [1:0] stall_cnt;

   id_ex_stage #(
      .REG_ADDR_W (2),
      .DATA_W     (8),
      .CNT_W      (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_rs_used  (id_rs_used),
      .id_rt_used  (id_rt_used),
      .id_regwrite (id_ctl[5]),
      .id_memread  (id_ctl[4]),
      .id_memwrite (id_ctl[3]),
      .id_memtoreg (id_ctl[2]),
      .id_alusrc   (id_ctl[1]),
      .id_regdst   (id_ctl[0]),
      .id_aluop    (id_aluop),
      .id_rdata1   (id_rdata1),
      .id_rdata2   (id_rdata2),
      .id_imm      (id_imm),
      .flush       (flush),
      .cnt_clr     (cnt_clr),
      .ex_valid    (ex_valid),
      .ex_rs       (ex_rs),
      .ex_rt       (ex_rt),
      .ex_rd       (ex_rd),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_memwrite (ex_memwrite),
      .ex_memtoreg (ex_memtoreg),
      .ex_alusrc   (ex_alusrc),
      .ex_regdst   (ex_regdst),
      .ex_aluop    (ex_aluop),
      .ex_rdata1   (ex_rdata1),
      .ex_rdata2   (ex_rdata2),
      .ex_imm      (ex_imm),
      .stall       (stall),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model of what EX should hold: the instruction last accepted into EX.
   logic       m_valid;
   logic [1:0] m_rs, m_rt, m_rd, m_aluop;
   logic [5:0] m_ctl;
   logic [7:0] m_d1, m_d2, m_imm;
   int         m_cnt;
   logic       last_stall;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0; m_aluop = '0; m_ctl = '0;
      m_d1 = '0; m_d2 = '0; m_imm = '0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ":ctl"},
               32'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                    ex_alusrc, ex_regdst, ex_aluop}),
               32'({m_valid, m_ctl, m_aluop}));
      check_eq({tag, ":addr"}, 32'({ex_rs, ex_rt, ex_rd}), 32'({m_rs, m_rt, m_rd}));
      check_eq({tag, ":data"}, 32'({ex_rdata1, ex_rdata2, ex_imm}), 32'({m_d1, m_d2, m_imm}));
      check_eq({tag, ":cnt"}, 32'(stall_cnt), 32'(m_cnt));
   endtask

   // Inputs must already be applied; checks stall before the edge and EX after it.
   task automatic cycle(input string tag);
      logic reads_load, st, squash;
      #1;
      reads_load = (id_rs_used && id_rs == m_rt) || (id_rt_used && id_rt == m_rt);
      st = m_valid && m_ctl[4] && (m_rt != 2'd0) && id_valid && reads_load && !flush;
      check_eq({tag, ":stall"}, 32'(stall), 32'(st));
      @(posedge clk);
      squash = flush || st;
      if (cnt_clr) m_cnt = 0;
      else if (st) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm;
      m_valid = squash ? 1'b0 : id_valid;
      m_ctl   = squash ? 6'd0 : id_ctl;
      m_aluop = squash ? 2'd0 : id_aluop;
      last_stall = st;
      #1;
      check_outputs(tag);
   endtask

   task automatic set_inst(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                           input logic [1:0] rd, input logic rsu, input logic rtu,
                           input logic [5:0] ctl);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_used = rsu; id_rt_used = rtu; id_ctl = ctl;
      id_aluop = 2'($urandom); id_rdata1 = 8'($urandom); id_rdata2 = 8'($urandom);
      id_imm = 8'($urandom); flush = 1'b0; cnt_clr = 1'b0;
   endtask

   localparam logic [5:0] CtlLw  = 6'b110110;
   localparam logic [5:0] CtlAlu = 6'b100001;

   initial begin
      rst_n = 1'b0;
      set_inst(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
      model_reset();
      last_stall = 1'b0;
      #2;
      check_outputs("reset0");
      check_eq("reset0:stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Pass-through
      set_inst(1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 1'b1, 6'b100000);
      id_rdata1 = 8'h5A; id_imm = 8'hF3;
      cycle("pass");
      check_eq("pass:direct", 32'({ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_rdata1, ex_imm}),
               32'({1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 8'h5A, 8'hF3}));

      // Asynchronous reset between edges with nonzero EX contents
      #2; rst_n = 1'b0; #1;
      model_reset();
      check_outputs("areset");
      check_eq("areset:stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      #1;

      // Load-use stall then capture of the held instruction
      set_inst(1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, CtlLw);
      cycle("lw1");
      set_inst(1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 1'b1, CtlAlu);
      #1 check_eq("lu:stall_hi", 32'(stall), 32'd1);
      cycle("lu_s1");
      check_eq("lu_s1:bubble", 32'({ex_valid, ex_memread, ex_regwrite, stall_cnt}), 32'(5'b00001));
      cycle("lu_s2");
      check_eq("lu_s2:held", 32'({ex_valid, ex_rs}), 32'({1'b1, 2'b01}));

      // Load to r0 never stalls
      set_inst(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, CtlLw);
      cycle("lw_r0");
      set_inst(1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, CtlAlu);
      cycle("r0_dep");
      // rt matches but rt not read
      set_inst(1'b1, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, CtlLw);
      cycle("lw_r2");
      set_inst(1'b1, 2'b01, 2'b10, 2'b11, 1'b1, 1'b0, CtlAlu);
      cycle("rt_unused");

      // Flush with hazard present
      set_inst(1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, CtlLw);
      cycle("lw_f");
      set_inst(1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0, CtlAlu);
      flush = 1'b1;
      cycle("flush");
      check_eq("flush:bubble", 32'({ex_valid, ex_regwrite, stall_cnt}), 32'(4'b0001));

      // Saturation: five more stalls
      for (int i = 0; i < 5; i++) begin
         set_inst(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, CtlLw);
         cycle("sat_lw");
         set_inst(1'b1, 2'b00, 2'b11, 2'b01, 1'b0, 1'b1, CtlAlu);
         cycle("sat_st");
         cycle("sat_go");
      end
      check_eq("sat:cnt", 32'(stall_cnt), 32'd3);
      set_inst(1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, CtlLw);
      cycle("clr_lw");
      set_inst(1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, CtlAlu);
      cnt_clr = 1'b1;
      cycle("clr_st");
      check_eq("clr:cnt", 32'(stall_cnt), 32'd0);

      // Randomized traffic; the held instruction is kept stable across a stall
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            set_inst(($urandom_range(0, 7) != 0), 2'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom), 1'($urandom),
                     ($urandom_range(0, 1) != 0) ? CtlLw : 6'($urandom));
         end
         flush   = ($urandom_range(0, 9) == 0);
         cnt_clr = ($urandom_range(0, 15) == 0);
         cycle("rand");
      end

      // Reset in the middle of a stall
      set_inst(1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, CtlLw);
      cycle("mid_lw");
      set_inst(1'b1, 2'b10, 2'b01, 2'b11, 1'b1, 1'b1, CtlAlu);
      #1 check_eq("mid:stall_hi", 32'(stall), 32'd1);
      rst_n = 1'b0; #1;
      model_reset();
      check_eq("mid:stall_lo", 32'(stall), 32'd0);
      check_outputs("mid_rst");
      rst_n = 1'b1;
      cycle("post_rst");
      check_eq("post_rst:valid", 32'(ex_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
